// File: rtl/nibble_sequencer.sv
// nibble_sequencer: takes one 32-bit word from upstream and emits its nibbles
// one per symbol slot (nibble 0 first) to the symbol-to-chip spreader.
// Optional build macro SEQ_LAST_EN adds the outLast output marking the final
// symbol of each word.
module nibble_sequencer #(
  parameter int NUM_SYM = 8
) (
  input  logic        inClk,
  input  logic        inRst,
  input  logic [31:0] inData,
  input  logic        inValid,
  output logic        inReady,
  input  logic        inAbort,
  output logic [3:0]  outData,
  output logic [2:0]  outSel,
  output logic        outValid,
  input  logic        outReady,
  output logic        outBusy
`ifdef SEQ_LAST_EN
  ,
  output logic        outLast
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Valid never depends on ready; once outValid is raised,
  // outData/outSel stay stable until the symbol transfers (or abort/reset).
  // inReady is combinational: high in IDLE, and in SEND only when the last
  // symbol is transferring this cycle, so a new word loads with no bubble.

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [2:0] LAST_SEL = 3'(NUM_SYM - 1);

  state_t      state_q;
  logic [31:0] word_q;
  logic [2:0]  sel_q;
  logic        is_last;
  logic        accept;
  logic        out_xfer;

  assign is_last  = (sel_q == LAST_SEL);
  assign out_xfer = (state_q == SEND) && outReady;
  assign accept   = inValid && inReady;

  // Ready for a new word: idle, or finishing the last symbol; never during
  // reset or abort.
  always_comb begin
    inReady = 1'b0;
    if (!inRst && !inAbort) begin
      if (state_q == IDLE) begin
        inReady = 1'b1;
      end else begin
        inReady = outReady && is_last;
      end
    end
  end

  // Sequencer FSM: abort beats every transfer, word load beats symbol advance.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q <= IDLE;
      word_q  <= 32'h0;
      sel_q   <= 3'd0;
    end else if (state_q == SEND && inAbort) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
    end else if (accept) begin
      state_q <= SEND;
      word_q  <= inData;
      sel_q   <= 3'd0;
    end else if (out_xfer) begin
      if (is_last) begin
        state_q <= IDLE;
      end else begin
        sel_q <= sel_q + 3'd1;
      end
    end
  end

  // Nibble mux: select the held nibble addressed by the select counter.
  always_comb begin
    outData = 4'h0;
    case (sel_q)
      3'd0: outData = word_q[3:0];
      3'd1: outData = word_q[7:4];
      3'd2: outData = word_q[11:8];
      3'd3: outData = word_q[15:12];
      3'd4: outData = word_q[19:16];
      3'd5: outData = word_q[23:20];
      3'd6: outData = word_q[27:24];
      3'd7: outData = word_q[31:28];
      default: outData = 4'h0;
    endcase
  end

  assign outSel   = sel_q;
  assign outValid = (state_q == SEND);
  assign outBusy  = (state_q == SEND);

`ifdef SEQ_LAST_EN
  assign outLast = (state_q == SEND) && is_last;
`endif

endmodule

// File: tb/tb_nibble_sequencer.sv
// Bench for nibble_sequencer: drives an 8-symbol and a 4-symbol instance with
// the same inputs and compares both against a spec-level cycle model.
module tb_nibble_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_abort;
  logic        out_ready;

  logic       rdy8, val8, busy8, rdy4, val4, busy4;
  logic [3:0] d8, d4;
  logic [2:0] s8, s4;
`ifdef SEQ_LAST_EN
  logic       last8, last4;
`endif

  nibble_sequencer #(.NUM_SYM(8)) dut8 (
    .inClk(clk), .inRst(rst), .inData(in_data), .inValid(in_valid),
    .inReady(rdy8), .inAbort(in_abort), .outData(d8), .outSel(s8),
    .outValid(val8), .outReady(out_ready), .outBusy(busy8)
`ifdef SEQ_LAST_EN
    , .outLast(last8)
`endif
  );

  nibble_sequencer #(.NUM_SYM(4)) dut4 (
    .inClk(clk), .inRst(rst), .inData(in_data), .inValid(in_valid),
    .inReady(rdy4), .inAbort(in_abort), .outData(d4), .outSel(s4),
    .outValid(val4), .outReady(out_ready), .outBusy(busy4)
`ifdef SEQ_LAST_EN
    , .outLast(last4)
`endif
  );

  // ---------------- reference model + scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;

  bit          m_busy[2];
  logic [31:0] m_word[2];
  int          m_idx[2];
  int          m_n[2] = '{8, 4};
  bit          acc8;            // dut8 accepted a word at the last edge
  logic [3:0]  exp_q[$];        // symbols dut8 still owes downstream

  function automatic logic [3:0] nib(logic [31:0] w, int i);
    logic [31:0] t;
    t = (w >> (4 * i)) & 32'hF;
    return t[3:0];
  endfunction

  function automatic logic exp_ready(int k);
    return !rst && !in_abort &&
           (!m_busy[k] || (out_ready && m_idx[k] == m_n[k] - 1));
  endfunction

  // One cycle: compare outputs, score delivered symbols, advance model.
  task automatic step();
    logic       e_rdy[2];
    logic       a_rdy, a_val, a_busy, a_last;
    logic [3:0] a_d, e_d, sb;
    logic [2:0] a_s, e_s;
    #1;
    for (int k = 0; k < 2; k++) begin
      a_rdy  = (k == 0) ? rdy8  : rdy4;
      a_val  = (k == 0) ? val8  : val4;
      a_busy = (k == 0) ? busy8 : busy4;
      a_d    = (k == 0) ? d8    : d4;
      a_s    = (k == 0) ? s8    : s4;
      a_last = 1'b0;
`ifdef SEQ_LAST_EN
      a_last = (k == 0) ? last8 : last4;
`endif
      e_rdy[k] = exp_ready(k);
      e_d = nib(m_word[k], m_idx[k]);
      e_s = 3'(m_idx[k]);
      vectors++;
      if (a_rdy !== e_rdy[k]) begin
        miscompares++;
        $display("FAIL inReady n=%0d t=%0t got %b want %b", m_n[k], $time, a_rdy, e_rdy[k]);
      end
      vectors++;
      if (a_val !== m_busy[k]) begin
        miscompares++;
        $display("FAIL outValid n=%0d t=%0t got %b want %b", m_n[k], $time, a_val, m_busy[k]);
      end
      vectors++;
      if (a_busy !== m_busy[k]) begin
        miscompares++;
        $display("FAIL outBusy n=%0d t=%0t got %b want %b", m_n[k], $time, a_busy, m_busy[k]);
      end
      vectors++;
      if (a_s !== e_s) begin
        miscompares++;
        $display("FAIL outSel n=%0d t=%0t got %0d want %0d", m_n[k], $time, a_s, e_s);
      end
      vectors++;
      if (a_d !== e_d) begin
        miscompares++;
        $display("FAIL outData n=%0d t=%0t got %h want %h", m_n[k], $time, a_d, e_d);
      end
`ifdef SEQ_LAST_EN
      vectors++;
      if (a_last !== (m_busy[k] && m_idx[k] == m_n[k] - 1)) begin
        miscompares++;
        $display("FAIL outLast n=%0d t=%0t got %b", m_n[k], $time, a_last);
      end
`endif
    end
    // scoreboard for the 8-symbol instance (abort-cycle handshake counts)
    if (!rst && m_busy[0] && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_extra t=%0t got %h want none", $time, d8);
      end else begin
        sb = exp_q.pop_front();
        if (d8 !== sb) begin
          miscompares++;
          $display("FAIL sb_symbol t=%0t got %h want %h", $time, d8, sb);
        end
      end
    end
    if (rst || (m_busy[0] && in_abort)) exp_q.delete();
    acc8 = in_valid && e_rdy[0];
    if (acc8) for (int i = 0; i < 8; i++) exp_q.push_back(nib(in_data, i));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0; m_idx[k] = 0; m_word[k] = 32'h0;
      end else if (m_busy[k] && in_abort) begin
        m_busy[k] = 1'b0; m_idx[k] = 0;
      end else if (in_valid && e_rdy[k]) begin
        m_busy[k] = 1'b1; m_idx[k] = 0; m_word[k] = in_data;
      end else if (m_busy[k] && out_ready) begin
        if (m_idx[k] == m_n[k] - 1) m_busy[k] = 1'b0;
        else m_idx[k] = m_idx[k] + 1;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_idle();
    out_ready = 1'b1; in_valid = 1'b0; in_abort = 1'b0; rst = 1'b0;
    for (int i = 0; i < 40 && (m_busy[0] || m_busy[1]); i++) step();
    vectors++;
    if (m_busy[0] || m_busy[1]) begin
      miscompares++;
      $display("FAIL drain_timeout got busy want idle");
    end
  endtask

  task automatic send_word(logic [31:0] w);
    in_data = w; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_to_sel(int s);
    for (int i = 0; i < 20 && !(m_busy[0] && m_idx[0] == s); i++) step();
    vectors++;
    if (!(m_busy[0] && m_idx[0] == s)) begin
      miscompares++;
      $display("FAIL reach_sel got %0d want %0d", m_idx[0], s);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; step(); step();
    rst = 1'b0;
    #1;
    vectors++;
    if (rdy8 !== 1'b1 || val8 !== 1'b0 || d8 !== 4'h0 || s8 !== 3'd0 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values got rdy=%b val=%b d=%h s=%0d busy=%b want 1 0 0 0 0",
               rdy8, val8, d8, s8, busy8);
    end
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_word(32'h76543210);
    run_idle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h76543210;
    for (int w = 0; w < 2; w++) begin
      acc8 = 1'b0;
      for (int i = 0; i < 20 && !acc8; i++) step();
      vectors++;
      if (!acc8) begin
        miscompares++;
        $display("FAIL b2b_accept got none want word %0d", w);
      end
      in_data = 32'hFEDCBA98;
    end
    in_valid = 1'b0;
    run_idle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    send_word(32'hA5A5A5A5);
    run_to_sel(2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (d8 !== 4'h5 || s8 !== 3'd2 || val8 !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold got d=%h s=%0d v=%b want 5 2 1", d8, s8, val8);
      end
      step();
    end
    run_idle();
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    send_word(32'h76543210);
    run_to_sel(4);
    in_abort = 1'b1; in_valid = 1'b1; in_data = 32'h11111111;
    step();
    in_abort = 1'b0;
    #1;
    vectors++;
    if (val8 !== 1'b0 || s8 !== 3'd0 || rdy8 !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_idle got v=%b s=%0d rdy=%b want 0 0 1", val8, s8, rdy8);
    end
    step();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (val8 !== 1'b1 || d8 !== 4'h1 || s8 !== 3'd0) begin
      miscompares++;
      $display("FAIL abort_reload got v=%b d=%h s=%0d want 1 1 0", val8, d8, s8);
    end
    run_idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_word(32'h76543210);
    run_to_sel(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (val8 !== 1'b0 || d8 !== 4'h0 || s8 !== 3'd0 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got v=%b d=%h s=%0d b=%b want 0 0 0 0", val8, d8, s8, busy8);
    end
    send_word(32'h89ABCDEF);
    run_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 99) < 70);
      in_abort  = ($urandom_range(0, 99) < 4);
      rst       = ($urandom_range(0, 199) < 2);
      step();
    end
    run_idle();
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    rst = 1'b1; in_data = 32'h0; in_valid = 1'b0; in_abort = 1'b0; out_ready = 1'b1;
    acc8 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_idx[k] = 0; m_word[k] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
